bitserial_logic_unit: RTL

//  Multi-cycle, bit-serial logic unit for the 16-bit ALU datapath: accepts an

---
 rtl/bitserial_logic_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/bitserial_logic_unit.sv
// Bit-serial AND/OR/XOR/NOR unit: evaluates one bit per clock, LSB first,
// behind valid/ready handshakes on both the operand and the result side.
module bitserial_logic_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNTW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [1:0]       op_q;
   logic [CNTW-1:0]  cnt;
   logic             res_bit;
   logic [WIDTH-1:0] out_next;
   logic             accept;
   logic             last_bit;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last_bit  = (cnt == CNTW'(WIDTH - 1));

   always_comb begin
      res_bit = 1'b0;
      unique case (op_q)
         2'b00: res_bit = a_sh[0] & b_sh[0];
         2'b01: res_bit = a_sh[0] | b_sh[0];
         2'b10: res_bit = a_sh[0] ^ b_sh[0];
         2'b11: res_bit = ~(a_sh[0] | b_sh[0]);
         default: res_bit = 1'b0;
      endcase
   end

   // Result fills from the MSB end so the LSB-first bits land in place after WIDTH shifts.
   assign out_next = {res_bit, out[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (accept) state_next = RUN;
         RUN:  if (last_bit) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         op_q <= '0;
         cnt  <= '0;
         out  <= '0;
         zero <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_sh <= A;
                  b_sh <= B;
                  op_q <= op;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh <= {1'b0, b_sh[WIDTH-1:1]};
               out  <= out_next;
               if (last_bit) begin
                  // zero is taken from the completed word so it arrives with out_valid
                  zero <= (out_next == '0);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
